// File: rtl/addr_reg_pkg.sv
// ============================================================================
// Module  : addr_reg_pkg
// Brief   : Shared defaults and types for the matrix-multiply address generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package addr_reg_pkg;

    localparam int DEFAULT_N  = 8;
    localparam int DEFAULT_AW = 8;
    localparam int IDX_W      = $clog2(DEFAULT_N);

    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [DEFAULT_AW-1:0] addr_t;

endpackage

`default_nettype wire

// File: rtl/addr_reg_dp_mod_counter.sv
// ============================================================================
// Module  : mod_counter
// Brief   : Enabled modulo counter stepping by STEP, wrapping to 0 after MAX.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STEP);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + c_STEP;
        end
    end

    assign wrap  = en && (r_count == c_MAX);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/addr_reg_dp.sv
// ============================================================================
// Module  : addr_reg_dp
// Brief   : A/B operand address generator, two adjacent C columns per step.
//           Optional last/pair_done flags enabled by defining ADDR_REG_LAST_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module addr_reg_dp
    import addr_reg_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int AW     = DEFAULT_AW,
    parameter int A_BASE = 0,
    parameter int B_BASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Load,
    output logic [AW-1:0] addrA,
    output logic [AW-1:0] addrB1,
    output logic [AW-1:0] addrB2
`ifdef ADDR_REG_LAST_EN
    ,
    output logic          last,
    output logic          pair_done
`endif
);

    localparam int            c_IDX_W  = $clog2(N);
    localparam logic [AW-1:0] c_A_BASE = AW'(A_BASE);
    localparam logic [AW-1:0] c_B_BASE = AW'(B_BASE);
    localparam logic [AW-1:0] c_N      = AW'(N);

    logic [c_IDX_W-1:0] w_k;
    logic [c_IDX_W-1:0] w_j;
    logic [c_IDX_W-1:0] w_i;
    logic               w_kWrap;
    logic               w_jWrap;
    logic               w_unusedPassWrap;

    // k is innermost; each wrap enables the next counter out (k -> j -> i).
    mod_counter #(.WIDTH(c_IDX_W), .MAX(N - 1), .STEP(1)) u_kCounter (
        .clk   (clk),
        .reset (reset),
        .en    (Load),
        .count (w_k),
        .wrap  (w_kWrap)
    );

    mod_counter #(.WIDTH(c_IDX_W), .MAX(N - 2), .STEP(2)) u_jCounter (
        .clk   (clk),
        .reset (reset),
        .en    (w_kWrap),
        .count (w_j),
        .wrap  (w_jWrap)
    );

    mod_counter #(.WIDTH(c_IDX_W), .MAX(N - 1), .STEP(1)) u_iCounter (
        .clk   (clk),
        .reset (reset),
        .en    (w_jWrap),
        .count (w_i),
        .wrap  (w_unusedPassWrap)
    );

    logic [AW-1:0] w_bRow;

    assign w_bRow = c_B_BASE + AW'(w_k) * c_N;
    assign addrA  = c_A_BASE + AW'(w_i) * c_N + AW'(w_k);
    assign addrB1 = w_bRow + AW'(w_j);
    assign addrB2 = w_bRow + AW'(w_j) + AW'(1);

`ifdef ADDR_REG_LAST_EN
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N - 1);
    localparam logic [c_IDX_W-1:0] c_J_LAST   = c_IDX_W'(N - 2);

    assign pair_done = !reset && (w_k == c_IDX_LAST);
    assign last      = pair_done && (w_j == c_J_LAST) && (w_i == c_IDX_LAST);
`endif

endmodule

`default_nettype wire

// File: tb/tb_addr_reg_dp.sv
// ============================================================================
// Module  : tb_addr_reg_dp
// Brief   : Directed self-checking bench for addr_reg_dp at N = 8, AW = 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_addr_reg_dp;
    import addr_reg_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  Load;
    addr_t addrA;
    addr_t addrB1;
    addr_t addrB2;
`ifdef ADDR_REG_LAST_EN
    logic  last;
    logic  pair_done;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addr_reg_dp #(.N(8), .AW(8), .A_BASE(0), .B_BASE(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .Load      (Load),
        .addrA     (addrA),
        .addrB1    (addrB1),
        .addrB2    (addrB2)
`ifdef ADDR_REG_LAST_EN
        ,
        .last      (last),
        .pair_done (pair_done)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkTuple(input string tag, input logic [7:0] a, input logic [7:0] b1,
                              input logic [7:0] b2);
        check({tag, ".addrA"},  addrA,  a);
        check({tag, ".addrB1"}, addrB1, b1);
        check({tag, ".addrB2"}, addrB2, b2);
    endtask

    // Enables exactly n rising edges; starts and ends at a falling edge.
    task automatic pulse(input int n);
        Load = 1'b1;
        repeat (n) @(negedge clk);
        Load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        Load  = 1'b0;
        #100;
        @(negedge clk);
        checkTuple("reset", 8'd0, 8'd0, 8'd1);
        @(negedge clk);
        checkTuple("resetStable", 8'd0, 8'd0, 8'd1);
`ifdef ADDR_REG_LAST_EN
        check("resetLast", {7'd0, last}, 8'd0);
        check("resetPairDone", {7'd0, pair_done}, 8'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        checkTuple("idleAfterReset", 8'd0, 8'd0, 8'd1);

        pulse(1);
        checkTuple("edge1", 8'd1, 8'd8, 8'd9);
        pulse(7);
        checkTuple("edge8", 8'd0, 8'd2, 8'd3);
        pulse(24);
        checkTuple("edge32", 8'd8, 8'd0, 8'd1);
        pulse(223);
        checkTuple("edge255", 8'd63, 8'd62, 8'd63);
`ifdef ADDR_REG_LAST_EN
        check("edge255Last", {7'd0, last}, 8'd1);
        check("edge255PairDone", {7'd0, pair_done}, 8'd1);
`endif
        pulse(1);
        checkTuple("edge256Wrap", 8'd0, 8'd0, 8'd1);
`ifdef ADDR_REG_LAST_EN
        check("wrapLast", {7'd0, last}, 8'd0);
`endif

        pulse(5);
        checkTuple("hold5", 8'd5, 8'd40, 8'd41);
        repeat (5) @(negedge clk);
        checkTuple("holdMid", 8'd5, 8'd40, 8'd41);
        repeat (5) @(negedge clk);
        checkTuple("holdEnd", 8'd5, 8'd40, 8'd41);
        pulse(1);
        checkTuple("resume", 8'd6, 8'd48, 8'd49);

        // Toggle Load every other cycle: 3 more enabled edges (k 6 -> 1, j 0 -> 2).
        pulse(1); @(negedge clk);
        pulse(1); @(negedge clk);
        pulse(1);
        checkTuple("toggle", 8'd1, 8'd10, 8'd11);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse(100);
        checkTuple("edge100", 8'd28, 8'd32, 8'd33);

        Load = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1 checkTuple("asyncReset", 8'd0, 8'd0, 8'd0 + 8'd1);
        repeat (2) @(negedge clk);
        checkTuple("resetDominates", 8'd0, 8'd0, 8'd1);
        reset = 1'b0;
        @(negedge clk);
        Load = 1'b0;
        checkTuple("afterResetEdge1", 8'd1, 8'd8, 8'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
